// File: rtl/alu_arb2.sv
// Two-requester 16-bit ALU with round-robin arbitration.
// Each operation takes three states in turn: accept (IDLE), compute (EXEC) and response handshake (RESP).
module alu_arb2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_owner;
    logic        r_last;
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic        r_zr;
    logic        r_ng;

    logic        w_winner;
    logic        w_accept;
    logic        w_rspDone;
    logic [15:0] w_aluOut;

    // On a tie, the requester that did not complete last wins.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        w_accept    = 1'b0;
        w_rspDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !w_winner;
                    req1_ready = req1_valid && w_winner;
                end
                w_accept = req0_ready || req1_ready;
                if (w_accept) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                if (!rst) begin
                    rsp0_valid = !r_owner;
                    rsp1_valid = r_owner;
                end
                // Only the owner's ready can close the handshake.
                w_rspDone = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
                if (w_rspDone) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        busy = (r_state != IDLE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_aluOut = 16'h0000;
        case (r_op)
            2'b00: w_aluOut = ~r_a;
            2'b01: w_aluOut = r_a & r_b;
            2'b10: w_aluOut = r_a + r_b;
            2'b11: w_aluOut = r_a - r_b;
            default: w_aluOut = 16'h0000;
        endcase
    end

    // Result flags reset to describe a zero result so rsp_zr reads 1 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_op     <= 2'b00;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_result <= 16'h0000;
            r_zr     <= 1'b1;
            r_ng     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_winner;
                r_op    <= w_winner ? req1_op : req0_op;
                r_a     <= w_winner ? req1_a  : req0_a;
                r_b     <= w_winner ? req1_b  : req0_b;
            end
            if (r_state == EXEC) begin
                r_result <= w_aluOut;
                r_zr     <= (w_aluOut == 16'h0000);
                r_ng     <= w_aluOut[15];
            end
            if (w_rspDone) begin
                r_last <= r_owner;
            end
        end
    end

    assign rsp_data = r_result;
    assign rsp_zr   = r_zr;
    assign rsp_ng   = r_ng;

endmodule
